// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - Stop/NoStop bit values and the cumulative stall masks
//   - 2-bit sequencer state encoding
//   - ERET exception code and default exception vector
//   - small decode helper for the MEM-stage exception word
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Stall masks: bit0=pc, bit1=if, bit2=id, bit3=ex, bit4=mem, bit5=wb.
    // A stage stall freezes itself and everything upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_EXC_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_REFILL   = 2'b11
    } ctrl_state_t;

    localparam logic [31:0] EXC_ERET           = 32'h0000000E;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC00380;

    // ERET returns to EPC; every other nonzero code goes to the vector.
    function automatic logic is_eret(input logic [31:0] exc);
        return (exc == EXC_ERET);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fetch_tracker.sv
// -----------------------------------------------------------------------------
// ctrl_fetch_tracker
// Counts instruction fetches in flight and, after a redirect, marks the stale
// responses that belong to the squashed path so the fetch stage drops them.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_req_fire       fetch request accepted by the instruction bus
//   if_resp_valid     fetch response returned
//   load_discard      sequencer is in FLUSH: snapshot in-flight count
//   refill_active     sequencer is in REFILL: consume stale responses
//   discard_load_nz   in-flight count after this cycle is nonzero
//   if_discard        drop the current fetch response
//   refill_done       last stale response arrives this cycle
// -----------------------------------------------------------------------------
module ctrl_fetch_tracker
    import pipeline_ctrl_pkg::*;
#(
    parameter int FETCH_CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_fire,
    input  logic if_resp_valid,
    input  logic load_discard,
    input  logic refill_active,
    output logic discard_load_nz,
    output logic if_discard,
    output logic refill_done
);

    localparam logic [FETCH_CNT_W-1:0] CNT_ZERO = {FETCH_CNT_W{1'b0}};
    localparam logic [FETCH_CNT_W-1:0] CNT_MAX  = {FETCH_CNT_W{1'b1}};
    localparam logic [FETCH_CNT_W-1:0] CNT_ONE  = {{(FETCH_CNT_W-1){1'b0}}, 1'b1};

    logic [FETCH_CNT_W-1:0] pending_r;
    logic [FETCH_CNT_W-1:0] pending_next_s;
    logic [FETCH_CNT_W-1:0] discard_r;

    // Next in-flight count: saturating up/down, simultaneous fire+resp cancel.
    always_comb begin
        pending_next_s = pending_r;
        if (if_req_fire && !if_resp_valid) begin
            if (pending_r != CNT_MAX) begin
                pending_next_s = pending_r + CNT_ONE;
            end else begin
                pending_next_s = pending_r;
            end
        end else if (!if_req_fire && if_resp_valid) begin
            if (pending_r != CNT_ZERO) begin
                pending_next_s = pending_r - CNT_ONE;
            end else begin
                pending_next_s = pending_r;
            end
        end else begin
            pending_next_s = pending_r;
        end
    end

    // In-flight fetch counter; runs in every sequencer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= CNT_ZERO;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Stale-response counter: loaded at FLUSH, drained by responses in REFILL.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_r <= CNT_ZERO;
        end else if (load_discard) begin
            discard_r <= pending_next_s;
        end else if (refill_active && if_resp_valid && (discard_r != CNT_ZERO)) begin
            discard_r <= discard_r - CNT_ONE;
        end else begin
            discard_r <= discard_r;
        end
    end

    assign discard_load_nz = (pending_next_s != CNT_ZERO);
    assign if_discard      = refill_active & if_resp_valid;
    // <= 1 rather than == 1 so a zero count can never strand the sequencer.
    assign refill_done     = refill_active & if_resp_valid & (discard_r <= CNT_ONE);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Merges per-stage
// stall requests into the 6-bit stall vector, and on a committed MEM-stage
// exception/ERET freezes, flushes and redirects the pipeline, then waits for
// stale fetch responses to drain.
//
// Optional build macro: CTRL_PERF_EN adds perf_stall_cycles/perf_flush_count.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   stallreq_if/id/ex/mem per-stage stall requests
//   i_except             MEM-stage exception word (0 = none, 0xE = ERET)
//   i_cp0_epc            current CP0 EPC
//   if_req_fire          fetch request accepted
//   if_resp_valid        fetch response returned
//   stall[5:0]           pc/if/id/ex/mem/wb freeze (1 = stop)
//   flush                clear pipeline registers and load new_pc
//   new_pc               redirect target, valid while flush=1
//   if_discard           drop current fetch response
//   busy                 sequencer not in RUN
//   perf_stall_cycles    (CTRL_PERF_EN) cycles with any stall bit set
//   perf_flush_count     (CTRL_PERF_EN) number of FLUSH cycles
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = DEFAULT_EXC_VECTOR,
    parameter int          FETCH_CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] i_except,
    input  logic [31:0] i_cp0_epc,
    input  logic        if_req_fire,
    input  logic        if_resp_valid,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        if_discard,
    output logic        busy
`ifdef CTRL_PERF_EN
   ,output logic [31:0] perf_stall_cycles
   ,output logic [31:0] perf_flush_count
`endif
);

    ctrl_state_t state_r;
    ctrl_state_t next_state_s;
    logic [31:0] target_q;
    logic        capture_s;
    logic [5:0]  stall_s;
    logic        discard_load_nz_s;
    logic        refill_done_s;

    ctrl_fetch_tracker #(
        .FETCH_CNT_W (FETCH_CNT_W)
    ) u_fetch_tracker (
        .clk             (clk),
        .reset           (reset),
        .if_req_fire     (if_req_fire),
        .if_resp_valid   (if_resp_valid),
        .load_discard    (state_r == ST_FLUSH),
        .refill_active   (state_r == ST_REFILL),
        .discard_load_nz (discard_load_nz_s),
        .if_discard      (if_discard),
        .refill_done     (refill_done_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, stall vector and redirect-capture strobe.
    always_comb begin
        next_state_s = state_r;
        stall_s      = STALL_NONE;
        capture_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_except != 32'h0) begin
                    stall_s = STALL_ALL;
                    if (stallreq_mem) begin
                        next_state_s = ST_EXC_WAIT;
                    end else begin
                        capture_s    = 1'b1;
                        next_state_s = ST_FLUSH;
                    end
                end else if (stallreq_mem) begin
                    stall_s = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall_s = STALL_EX;
                end else if (stallreq_id) begin
                    stall_s = STALL_ID;
                end else if (stallreq_if) begin
                    stall_s = STALL_IF;
                end else begin
                    stall_s = STALL_NONE;
                end
            end
            ST_EXC_WAIT: begin
                stall_s = STALL_ALL;
                if (!stallreq_mem) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_EXC_WAIT;
                end
            end
            ST_FLUSH: begin
                stall_s = STALL_NONE;
                if (discard_load_nz_s) begin
                    next_state_s = ST_REFILL;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_REFILL: begin
                stall_s = STALL_IF;
                if (refill_done_s) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_REFILL;
                end
            end
            default: begin
                stall_s      = STALL_NONE;
                next_state_s = ST_RUN;
            end
        endcase
    end

    // Redirect target, sampled from the exception word of the capture cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q <= 32'h0;
        end else if (capture_s) begin
            target_q <= is_eret(i_except) ? i_cp0_epc : EXC_VECTOR;
        end else begin
            target_q <= target_q;
        end
    end

    assign stall  = stall_s;
    assign flush  = (state_r == ST_FLUSH);
    assign new_pc = (state_r == ST_FLUSH) ? target_q : 32'h0;
    assign busy   = (state_r != ST_RUN);

`ifdef CTRL_PERF_EN
    // Performance counters; free-running, wrap modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= 32'h0;
            perf_flush_count  <= 32'h0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + ((stall_s != STALL_NONE) ? 32'd1 : 32'd0);
            perf_flush_count  <= perf_flush_count + ((state_r == ST_FLUSH) ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed self-checking bench for pipeline_ctrl (default build).
// Inputs change 1 time unit after the rising edge; outputs are checked one
// further time unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] i_except, i_cp0_epc;
    logic        if_req_fire, if_resp_valid;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        if_discard;
    logic        busy;

    int check_cnt = 0;
    int err_cnt   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .i_except      (i_except),
        .i_cp0_epc     (i_cp0_epc),
        .if_req_fire   (if_req_fire),
        .if_resp_valid (if_resp_valid),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .if_discard    (if_discard),
        .busy          (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        i_except      = 32'h0;
        i_cp0_epc     = 32'h0;
        if_req_fire   = 1'b0;
        if_resp_valid = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        settle();
        check_eq("rst_stall", 32'(stall), 32'h0);
        check_eq("rst_flush", 32'(flush), 32'h0);
        check_eq("rst_new_pc", new_pc, 32'h0);
        check_eq("rst_discard", 32'(if_discard), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);

        // Stall priority
        stallreq_if = 1'b1;
        settle();
        check_eq("stall_if", 32'(stall), 32'h03);
        stallreq_id = 1'b1;
        settle();
        check_eq("stall_id", 32'(stall), 32'h07);
        stallreq_ex = 1'b1;
        settle();
        check_eq("stall_ex_id", 32'(stall), 32'h0F);
        step();
        stallreq_mem = 1'b1;
        settle();
        check_eq("stall_mem", 32'(stall), 32'h1F);
        check_eq("stall_mem_noflush", 32'(flush), 32'h0);
        step();
        check_eq("stall_mem_nobusy", 32'(busy), 32'h0);
        clear_inputs();
        settle();
        check_eq("stall_none", 32'(stall), 32'h0);

        // General exception, no mem stall, nothing in flight
        step();
        i_except = 32'h00000010;
        settle();
        check_eq("exc_stall_all", 32'(stall), 32'h3F);
        check_eq("exc_noflush_yet", 32'(flush), 32'h0);
        step();
        i_except = 32'h0;
        settle();
        check_eq("exc_flush", 32'(flush), 32'h1);
        check_eq("exc_new_pc", new_pc, 32'hBFC00380);
        check_eq("exc_flush_stall", 32'(stall), 32'h0);
        check_eq("exc_flush_busy", 32'(busy), 32'h1);
        step();
        check_eq("exc_back_busy", 32'(busy), 32'h0);
        check_eq("exc_back_flush", 32'(flush), 32'h0);
        check_eq("exc_back_new_pc", new_pc, 32'h0);

        // ERET redirects to EPC
        i_except  = 32'h0000000E;
        i_cp0_epc = 32'hBFC01234;
        settle();
        check_eq("eret_stall_all", 32'(stall), 32'h3F);
        step();
        clear_inputs();
        settle();
        check_eq("eret_flush", 32'(flush), 32'h1);
        check_eq("eret_new_pc", new_pc, 32'hBFC01234);
        step();
        check_eq("eret_back_busy", 32'(busy), 32'h0);

        // Exception held off by a 3-cycle data-bus transaction; ERET target
        // must come from the EPC present on the release cycle
        i_except     = 32'h0000000E;
        i_cp0_epc    = 32'h11110000;
        stallreq_mem = 1'b1;
        settle();
        check_eq("wait_c0_stall", 32'(stall), 32'h3F);
        check_eq("wait_c0_flush", 32'(flush), 32'h0);
        for (int i = 1; i < 3; i++) begin
            step();
            check_eq("wait_cn_stall", 32'(stall), 32'h3F);
            check_eq("wait_cn_flush", 32'(flush), 32'h0);
            check_eq("wait_cn_busy", 32'(busy), 32'h1);
        end
        step();
        stallreq_mem = 1'b0;
        i_cp0_epc    = 32'h22220000;
        settle();
        check_eq("wait_c3_stall", 32'(stall), 32'h3F);
        check_eq("wait_c3_flush", 32'(flush), 32'h0);
        step();
        clear_inputs();
        settle();
        check_eq("wait_flush", 32'(flush), 32'h1);
        check_eq("wait_new_pc", new_pc, 32'h22220000);
        step();
        check_eq("wait_back_busy", 32'(busy), 32'h0);

        // Two fetches in flight, then an exception: both responses discarded
        if_req_fire = 1'b1;
        step();
        step();
        if_req_fire = 1'b0;
        i_except    = 32'h00000010;
        settle();
        check_eq("ref_exc_stall", 32'(stall), 32'h3F);
        step();
        i_except = 32'h0;
        settle();
        check_eq("ref_flush", 32'(flush), 32'h1);
        step();
        check_eq("ref_stall", 32'(stall), 32'h03);
        check_eq("ref_busy", 32'(busy), 32'h1);
        check_eq("ref_nodiscard_idle", 32'(if_discard), 32'h0);
        step();
        if_resp_valid = 1'b1;
        settle();
        check_eq("ref_discard1", 32'(if_discard), 32'h1);
        step();
        check_eq("ref_discard2", 32'(if_discard), 32'h1);
        check_eq("ref_busy2", 32'(busy), 32'h1);
        step();
        if_resp_valid = 1'b0;
        settle();
        check_eq("ref_done_busy", 32'(busy), 32'h0);
        check_eq("ref_done_stall", 32'(stall), 32'h0);
        if_req_fire = 1'b1;
        step();
        if_req_fire   = 1'b0;
        if_resp_valid = 1'b1;
        settle();
        check_eq("ref_third_kept", 32'(if_discard), 32'h0);
        step();
        if_resp_valid = 1'b0;

        // Reset during REFILL with two stale responses outstanding
        if_req_fire = 1'b1;
        step();
        step();
        if_req_fire = 1'b0;
        i_except    = 32'h00000010;
        step();
        i_except = 32'h0;
        step();
        check_eq("rr_in_refill", 32'(stall), 32'h03);
        reset = 1'b1;
        step();
        reset         = 1'b0;
        if_resp_valid = 1'b1;
        settle();
        check_eq("rr_stall", 32'(stall), 32'h0);
        check_eq("rr_discard", 32'(if_discard), 32'h0);
        check_eq("rr_busy", 32'(busy), 32'h0);
        step();
        check_eq("rr_discard_next", 32'(if_discard), 32'h0);
        check_eq("rr_busy_next", 32'(busy), 32'h0);
        step();
        if_resp_valid = 1'b0;

        // Saturation: 9 fires clamp at 7; a fire+resp in the FLUSH cycle
        // leaves 7 stale responses to discard, the 8th is kept
        if_req_fire = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
        end
        if_req_fire = 1'b0;
        i_except    = 32'h00000010;
        step();
        i_except      = 32'h0;
        if_req_fire   = 1'b1;
        if_resp_valid = 1'b1;
        settle();
        check_eq("sat_flush", 32'(flush), 32'h1);
        step();
        if_req_fire = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check_eq("sat_discard", 32'(if_discard), 32'h1);
            check_eq("sat_busy", 32'(busy), 32'h1);
            step();
        end
        check_eq("sat_done_busy", 32'(busy), 32'h0);
        check_eq("sat_kept", 32'(if_discard), 32'h0);
        step();
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg and every inter-stage register (if_id … mem_wb). Also accepts committed exceptions/ERET from the MEM stage and freezes, flushes and redirects the pipeline. Tracks outstanding instruction fetches so stale responses after a redirect are discarded.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception entry PC
FETCH_CNT_W, 3, width of the outstanding-fetch counter (max 2^W-1 in flight)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
stallreq_if  in  1  fetch stage waiting on instruction bus
stallreq_id  in  1  decode load-use hazard
stallreq_ex  in  1  multi-cycle mul/div busy
stallreq_mem  in  1  data bus transaction in flight
i_except  in  32  MEM-stage exception word; nonzero = exception, 32'h0000000E = ERET
i_cp0_epc  in  32  current CP0 EPC
if_req_fire  in  1  fetch request accepted by instruction bus
if_resp_valid  in  1  fetch response returned
stall  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1=Stop
flush  out  1  clear all pipeline registers and load new_pc
new_pc  out  32  redirect target, valid while flush=1
if_discard  out  1  drop the current fetch response
busy  out  1  state != RUN

Behaviour:
- Reset: state=RUN, stall=6'b000000, flush=0, new_pc=0, if_discard=0, busy=0, pending=0, discard_cnt=0, target_q=0.
- stall combinational in RUN, highest wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 0.
- FSM states RUN, EXC_WAIT, FLUSH, REFILL:
  - RUN: i_except!=0 and !stallreq_mem -> latch target_q (ERET ? i_cp0_epc : EXC_VECTOR); stall=6'b111111 this cycle; next FLUSH. i_except!=0 and stallreq_mem -> stall=6'b111111; next EXC_WAIT.
  - EXC_WAIT: stall=6'b111111. On the first cycle with stallreq_mem=0, latch target_q from the then-current i_except/i_cp0_epc; next FLUSH.
  - FLUSH: exactly one cycle. flush=1, new_pc=target_q, stall=0. discard_cnt <= pending net of this cycle's fire/resp. Next REFILL if that value is nonzero, else RUN.
  - REFILL: stall=6'b000011. if_discard=if_resp_valid. Decrement discard_cnt per response. Next RUN when discard_cnt reaches 0 via a response this cycle.
- flush and new_pc are Moore outputs decoded from state FLUSH. new_pc=0 outside FLUSH.
- pending counter: +1 on if_req_fire, -1 on if_resp_valid; both in the same cycle -> unchanged. Saturates at all-ones and does not wrap below 0. It keeps counting in every state.
- i_except is ignored in FLUSH and REFILL; the flush has already squashed the MEM stage.
- Reset asserted in any state returns to RUN the next edge, with all counters cleared.
- busy = (state != RUN).

Optional Feature:
- Macro: CTRL_PERF_EN.
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_count[31:0].
  - perf_stall_cycles increments on any cycle with stall!=0.
  - perf_flush_count increments on each FLUSH cycle.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports absent, no counter logic.

Decomposition:
- global_define.vh (shared package) holds:
  - Stop/NoStop and the stall masks STALL_NONE/IF/ID/EX/MEM/ALL
  - state encodings (2-bit)
  - EXC_ERET code 32'h0000000E
  - default EXC_VECTOR
- One sub-module, ctrl_fetch_tracker, owns the pending and discard counters, if_discard and the refill-done flag. The top keeps the FSM and stall encoding.

Test Plan:
- stallreq_ex=1, stallreq_id=1 simultaneously -> stall=6'b001111. Then stallreq_mem=1 -> stall=6'b011111, no flush.
- i_except=32'h00000010, no mem stall, pending=0 -> stall=6'b111111 for 1 cycle; next cycle flush=1, new_pc=32'hBFC00380; then back in RUN, busy=0.
- i_except=32'h0000000E, i_cp0_epc=32'hBFC01234 -> flush one cycle later with new_pc=32'hBFC01234.
- Exception while stallreq_mem=1 for 3 cycles -> stall=6'b111111 for 4 cycles total, then flush; no flush during the wait.
- Two fetches fired, none returned, then exception -> REFILL with stall=6'b000011; next two responses get if_discard=1; then RUN, and the third response has if_discard=0.
- Reset asserted during REFILL with discard_cnt=2 -> next edge state=RUN, stall=0, if_discard=0; subsequent responses not discarded.
